cmd_seq_checker: RTL and testbench

Synthesizable command sequencer/checker for the Knight's Tour bench and on-board self-test. It sits between a host that preloads a queue of 16-bit commands and the RemoteComm master. It issues each command, waits for `cmd_sent` and, optionally, for the response byte. Each response is compared against a positive-acknowledge value, with per-phase timeouts, and pass/error counts are kept. It generalises the single-command send/check-ack sequence into a parametrised, queued, self-timed engine.

---
 rtl/cmd_seq_checker_if.sv | 27 ++
 rtl/cmd_seq_checker.sv | 222 ++++++++++++++++++++++
 tb/tb_cmd_seq_checker.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_seq_checker_if.sv
// RemoteComm-side handshake bundle for cmd_seq_checker.
// master = sequencer (drives cmd/send_cmd), slave = RemoteComm model or core.
interface cmd_seq_checker_if #(
    parameter int CMD_W = 16
);
    logic [CMD_W-1:0] cmd;
    logic             send_cmd;
    logic             cmd_sent;
    logic             resp_rdy;
    logic [7:0]       resp;

    modport master (
        output cmd,
        output send_cmd,
        input  cmd_sent,
        input  resp_rdy,
        input  resp
    );

    modport slave (
        input  cmd,
        input  send_cmd,
        output cmd_sent,
        output resp_rdy,
        output resp
    );
endinterface

// File: rtl/cmd_seq_checker.sv
// Queued command sequencer: issues preloaded commands to RemoteComm and scores the replies.
// Optional macro SEQ_CHK_STOP_ON_ERR_EN: first mismatch/timeout flushes the queue and ends the run.
module cmd_seq_checker #(
    parameter int         DEPTH   = 8,
    parameter int         CMD_W   = 16,
    parameter int         TIMEOUT = 1_000_000,
    parameter logic [7:0] ACK     = 8'hA5,
    parameter int         CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [CMD_W-1:0]  load_cmd,
    input  logic              load_exp,
    output logic              full,
    input  logic              start,
    output logic              busy,
    output logic              done,
    cmd_seq_checker_if.master rc,
    output logic [7:0]        last_resp,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              tmo_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_SENT,
        S_WAIT_RESP,
        S_NEXT
    } state_t;

    // Queue storage: bit CMD_W is the "expects response" flag.
    logic [CMD_W:0]   mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;

    state_t           state_q;
    logic [CMD_W-1:0] cmd_q;
    logic             exp_q;
    logic             send_cmd_q;
    logic             busy_q;
    logic             done_q;
    logic [TW-1:0]    tmo_q;
    logic [7:0]       last_resp_q;
    logic [CNT_W-1:0] pass_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             tmo_err_q;

    logic             full_d;
    logic             load_ok_d;
    logic             tmo_hit_d;
    logic             resp_take_d;
    logic             tmo_fire_d;
    logic             pass_ev_d;
    logic             err_ev_d;
    logic             sent_only_d;
    logic             to_resp_d;
    logic [AW-1:0]    rd_ptr_d;
    logic [AW-1:0]    wr_ptr_d;
    logic [CNT_W-1:0] pass_cnt_d;
    logic [CNT_W-1:0] err_cnt_d;

    always_comb begin
        full_d      = (count_q == CW'(DEPTH));
        load_ok_d   = load && !busy_q && !full_d;
        tmo_hit_d   = (tmo_q == TW'(TIMEOUT - 1));
        resp_take_d = 1'b0;
        tmo_fire_d  = 1'b0;
        sent_only_d = 1'b0;
        to_resp_d   = 1'b0;
        case (state_q)
            S_WAIT_SENT: begin
                // A reply arriving together with cmd_sent is scored right away.
                resp_take_d = rc.cmd_sent && exp_q && rc.resp_rdy;
                sent_only_d = rc.cmd_sent && !exp_q;
                to_resp_d   = rc.cmd_sent && exp_q && !rc.resp_rdy;
                tmo_fire_d  = !rc.cmd_sent && tmo_hit_d;
            end
            S_WAIT_RESP: begin
                resp_take_d = rc.resp_rdy;
                tmo_fire_d  = !rc.resp_rdy && tmo_hit_d;
            end
            default: begin
            end
        endcase
        pass_ev_d  = resp_take_d && (rc.resp == ACK);
        err_ev_d   = (resp_take_d && (rc.resp != ACK)) || tmo_fire_d;
        rd_ptr_d   = rd_ptr_q + AW'(1);
        wr_ptr_d   = wr_ptr_q + AW'(1);
        pass_cnt_d = (&pass_cnt_q) ? pass_cnt_q : pass_cnt_q + CNT_W'(1);
        err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
    end

    // Storage has no reset so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (load_ok_d) begin
            mem_q[wr_ptr_q] <= {load_exp, load_cmd};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            cmd_q       <= '0;
            exp_q       <= 1'b0;
            send_cmd_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= '0;
            last_resp_q <= '0;
            pass_cnt_q  <= '0;
            err_cnt_q   <= '0;
            tmo_err_q   <= 1'b0;
        end else begin
            send_cmd_q <= 1'b0;
            done_q     <= 1'b0;

            if (load_ok_d) begin
                wr_ptr_q <= wr_ptr_d;
                count_q  <= count_q + CW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pass_cnt_q <= '0;
                        err_cnt_q  <= '0;
                        tmo_err_q  <= 1'b0;
                        if (count_q != '0) begin
                            state_q        <= S_ISSUE;
                            busy_q         <= 1'b1;
                            send_cmd_q     <= 1'b1;
                            {exp_q, cmd_q} <= mem_q[rd_ptr_q];
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    state_q <= S_WAIT_SENT;
                    tmo_q   <= '0;
                end

                S_WAIT_SENT, S_WAIT_RESP: begin
                    if (resp_take_d) begin
                        last_resp_q <= rc.resp;
                    end
                    if (pass_ev_d) begin
                        pass_cnt_q <= pass_cnt_d;
                    end
                    if (err_ev_d) begin
                        err_cnt_q <= err_cnt_d;
                    end
                    if (tmo_fire_d) begin
                        tmo_err_q <= 1'b1;
                    end

                    if (err_ev_d) begin
`ifdef SEQ_CHK_STOP_ON_ERR_EN
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        rd_ptr_q <= '0;
                        wr_ptr_q <= '0;
                        count_q  <= '0;
`else
                        state_q <= S_NEXT;
`endif
                    end else if (pass_ev_d || sent_only_d) begin
                        state_q <= S_NEXT;
                    end else if (to_resp_d) begin
                        state_q <= S_WAIT_RESP;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end

                S_NEXT: begin
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q        <= S_ISSUE;
                        send_cmd_q     <= 1'b1;
                        {exp_q, cmd_q} <= mem_q[rd_ptr_d];
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign full        = full_d;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rc.cmd      = cmd_q;
    assign rc.send_cmd = send_cmd_q;
    assign last_resp   = last_resp_q;
    assign pass_cnt    = pass_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign tmo_err     = tmo_err_q;

endmodule

// File: tb/tb_cmd_seq_checker.sv
// Scoreboard bench for cmd_seq_checker: stimulus queues expected commands and end-of-run
// results, a RemoteComm model answers each send_cmd, and a monitor scores every output event.
module tb_cmd_seq_checker;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_cmd = '0;
    logic        load_exp = 1'b0;
    logic        start = 1'b0;
    logic        full;
    logic        busy;
    logic        done;
    logic [7:0]  last_resp;
    logic [7:0]  pass_cnt;
    logic [7:0]  err_cnt;
    logic        tmo_err;

    always #5 clk = ~clk;

    cmd_seq_checker_if #(.CMD_W(16)) rc ();

    cmd_seq_checker #(
        .DEPTH  (8),
        .CMD_W  (16),
        .TIMEOUT(TMO),
        .ACK    (8'hA5),
        .CNT_W  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_cmd (load_cmd),
        .load_exp (load_exp),
        .full     (full),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rc       (rc),
        .last_resp(last_resp),
        .pass_cnt (pass_cnt),
        .err_cnt  (err_cnt),
        .tmo_err  (tmo_err)
    );

    typedef struct {
        int         sent_dly;
        bit         do_sent;
        bit         do_resp;
        int         resp_dly;
        logic [7:0] val;
    } beh_t;

    typedef struct {
        logic [7:0] pass;
        logic [7:0] err;
        logic       tmo;
        logic [7:0] last;
    } done_t;

    beh_t        beh_q[$];
    logic [15:0] exp_cmd_q[$];
    done_t       exp_done_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic void add_beh(input int sd, input bit ds, input bit dr, input int rd,
                                    input logic [7:0] v);
        beh_t b;
        b.sent_dly = sd;
        b.do_sent  = ds;
        b.do_resp  = dr;
        b.resp_dly = rd;
        b.val      = v;
        beh_q.push_back(b);
    endfunction

    function automatic void add_done(input logic [7:0] p, input logic [7:0] e, input logic t,
                                     input logic [7:0] l);
        done_t d;
        d.pass = p;
        d.err  = e;
        d.tmo  = t;
        d.last = l;
        exp_done_q.push_back(d);
    endfunction

    // RemoteComm model: one behaviour entry per observed send_cmd
    initial begin
        beh_t b;
        rc.cmd_sent = 1'b0;
        rc.resp_rdy = 1'b0;
        rc.resp     = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && rc.send_cmd === 1'b1 && beh_q.size() > 0) begin
                b = beh_q.pop_front();
                repeat (b.sent_dly) @(negedge clk);
                if (b.do_sent) begin
                    rc.cmd_sent = 1'b1;
                    if (b.do_resp && b.resp_dly == 0) begin
                        rc.resp_rdy = 1'b1;
                        rc.resp     = b.val;
                    end
                    @(negedge clk);
                    rc.cmd_sent = 1'b0;
                    rc.resp_rdy = 1'b0;
                    if (b.do_resp && b.resp_dly > 0) begin
                        repeat (b.resp_dly - 1) @(negedge clk);
                        rc.resp_rdy = 1'b1;
                        rc.resp     = b.val;
                        @(negedge clk);
                        rc.resp_rdy = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: scores every send_cmd and done pulse against the scoreboard queues
    initial begin
        logic [15:0] ec;
        done_t       ed;
        forever begin
            @(negedge clk);
            if (!rst && rc.send_cmd === 1'b1) begin
                $display("[%0t] send_cmd cmd=%04h", $time, rc.cmd);
                if (exp_cmd_q.size() == 0) begin
                    check("send_cmd not expected", 32'(rc.send_cmd), 32'd0);
                end else begin
                    ec = exp_cmd_q.pop_front();
                    check("cmd value", 32'(rc.cmd), 32'(ec));
                end
            end
            if (!rst && done === 1'b1) begin
                $display("[%0t] done pass=%0d err=%0d tmo=%0b last=%02h",
                         $time, pass_cnt, err_cnt, tmo_err, last_resp);
                if (exp_done_q.size() == 0) begin
                    check("done not expected", 32'(done), 32'd0);
                end else begin
                    ed = exp_done_q.pop_front();
                    check("done pass_cnt", 32'(pass_cnt), 32'(ed.pass));
                    check("done err_cnt", 32'(err_cnt), 32'(ed.err));
                    check("done tmo_err", 32'(tmo_err), 32'(ed.tmo));
                    check("done last_resp", 32'(last_resp), 32'(ed.last));
                end
            end
        end
    end

    task automatic load_one(input logic [15:0] c, input logic e);
        load     = 1'b1;
        load_cmd = c;
        load_exp = e;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({name, " done seen"}, 32'(done), 32'd1);
        check({name, " busy low at done"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
        $fatal(1);
    end

    initial begin
        int k;
        bit seen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check("reset full", 32'(full), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset send_cmd", 32'(rc.send_cmd), 32'd0);
        check("reset cmd", 32'(rc.cmd), 32'd0);
        check("reset last_resp", 32'(last_resp), 32'd0);
        check("reset pass_cnt", 32'(pass_cnt), 32'd0);
        check("reset err_cnt", 32'(err_cnt), 32'd0);
        check("reset tmo_err", 32'(tmo_err), 32'd0);

        // two entries, ACK reply on the first
        load_one(16'h2000, 1'b1);
        load_one(16'h3400, 1'b0);
        exp_cmd_q.push_back(16'h2000);
        exp_cmd_q.push_back(16'h3400);
        add_beh(2, 1'b1, 1'b1, 3, 8'hA5);
        add_beh(1, 1'b1, 1'b0, 0, 8'h00);
        add_done(8'd1, 8'd0, 1'b0, 8'hA5);
        pulse_start();
        check("start->busy", 32'(busy), 32'd1);
        check("start->send_cmd", 32'(rc.send_cmd), 32'd1);
        wait_done("two_entry");

        // mismatching reply
        load_one(16'h1234, 1'b1);
        exp_cmd_q.push_back(16'h1234);
        add_beh(1, 1'b1, 1'b1, 2, 8'h5A);
        add_done(8'd0, 8'd1, 1'b0, 8'h5A);
        pulse_start();
        wait_done("mismatch");

        // cmd_sent never arrives
        load_one(16'h0BAD, 1'b1);
        exp_cmd_q.push_back(16'h0BAD);
        add_beh(1, 1'b0, 1'b0, 0, 8'h00);
        add_done(8'd0, 8'd1, 1'b1, 8'h5A);
        pulse_start();
        check("timeout run send_cmd", 32'(rc.send_cmd), 32'd1);
        k = 0;
        while (tmo_err !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("timeout latency from send_cmd", 32'(k), 32'(TMO + 1));
        wait_done("timeout");

        // DEPTH+1 loads across pointer wrap
        for (int i = 0; i < 8; i++) begin
            load_one(16'hC000 | 16'(i), i[0]);
            check("full while loading", 32'(full), (i == 7) ? 32'd1 : 32'd0);
            exp_cmd_q.push_back(16'hC000 | 16'(i));
            if (i[0])
                add_beh(1, 1'b1, 1'b1, 1 + (i % 3), ((i % 4) == 1) ? 8'hA5 : 8'h33);
            else
                add_beh(2, 1'b1, 1'b0, 0, 8'h00);
        end
        load_one(16'hDEAD, 1'b0);
        check("full after dropped load", 32'(full), 32'd1);
        add_done(8'd2, 8'd2, 1'b0, 8'h33);
        pulse_start();
        wait_done("full_queue");
        check("full after run", 32'(full), 32'd0);

        // cmd_sent and resp_rdy in the same cycle
        load_one(16'h5555, 1'b1);
        exp_cmd_q.push_back(16'h5555);
        add_beh(2, 1'b1, 1'b1, 0, 8'hA5);
        add_done(8'd1, 8'd0, 1'b0, 8'hA5);
        pulse_start();
        wait_done("coincident");

        // start on an empty queue
        add_done(8'd0, 8'd0, 1'b0, 8'hA5);
        pulse_start();
        check("empty start done", 32'(done), 32'd1);
        check("empty start busy", 32'(busy), 32'd0);
        check("empty start send_cmd", 32'(rc.send_cmd), 32'd0);
        @(negedge clk);
        check("empty start done one cycle", 32'(done), 32'd0);

`ifdef SEQ_CHK_STOP_ON_ERR_EN
        // first error aborts and flushes
        load_one(16'hA001, 1'b1);
        load_one(16'hA002, 1'b0);
        load_one(16'hA003, 1'b1);
        exp_cmd_q.push_back(16'hA001);
        add_beh(1, 1'b1, 1'b1, 1, 8'h00);
        add_done(8'd0, 8'd1, 1'b0, 8'h00);
        pulse_start();
        wait_done("stop_on_err");
        add_done(8'd0, 8'd0, 1'b0, 8'h00);
        pulse_start();
        check("flushed queue start done", 32'(done), 32'd1);
        @(negedge clk);
`endif

        // reset while waiting for the response
        load_one(16'h7777, 1'b1);
        exp_cmd_q.push_back(16'h7777);
        add_beh(1, 1'b1, 1'b0, 0, 8'h00);
        pulse_start();
        repeat (6) @(negedge clk);
        check("busy before mid-run reset", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid-reset busy", 32'(busy), 32'd0);
        check("mid-reset cmd", 32'(rc.cmd), 32'd0);
        check("mid-reset send_cmd", 32'(rc.send_cmd), 32'd0);
        check("mid-reset last_resp", 32'(last_resp), 32'd0);
        check("mid-reset err_cnt", 32'(err_cnt), 32'd0);
        check("mid-reset tmo_err", 32'(tmo_err), 32'd0);
        check("mid-reset done", 32'(done), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("no done after abort", 32'(seen), 32'd0);

        // queue must be empty after reset
        add_done(8'd0, 8'd0, 1'b0, 8'h00);
        pulse_start();
        check("post-reset start done", 32'(done), 32'd1);
        repeat (3) @(negedge clk);

        check("pending commands", 32'(exp_cmd_q.size()), 32'd0);
        check("pending done events", 32'(exp_done_q.size()), 32'd0);
        check("pending responder entries", 32'(beh_q.size()), 32'd0);

        summary();
        $finish;
    end

endmodule
